zl_fifo_sc_flex: RTL

Parametrised single-clock show-ahead FIFO with inferred RAM storage, so no vendor IP is needed. It adds an exact-width occupancy count, programmable almost-full and almost-empty flags, a synchronous flush, and a sticky protocol-error flag. It uses the same req/ack handshake as the existing single-clock FIFO, drops in wherever that FIFO is used, and serves as the general buffering element between datapath stages.

---
 rtl/zl_fifo_sc_flex.sv | 83 ++++++++
 1 files changed

// File: rtl/zl_fifo_sc_flex.sv
// zl_fifo_sc_flex: single-clock show-ahead FIFO, inferred RAM plus head register,
// with occupancy count, almost flags, flush and sticky protocol-error flag.
module zl_fifo_sc_flex #(
    parameter int Data_width = 8,
    parameter int Addr_width = 4,
    parameter int Af_level   = 2**Addr_width-2,
    parameter int Ae_level   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_req,
    output logic                  in_ack,
    input  logic [Data_width-1:0] in_data,
    output logic                  out_req,
    input  logic                  out_ack,
    output logic [Data_width-1:0] out_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [Addr_width:0]   used,
    output logic                  proto_err
);
    localparam int Depth     = 2**Addr_width;
    localparam int Ram_depth = Depth-1;

    if (Af_level < 1 || Af_level > Depth) begin : g_af_chk
        $error("Af_level out of range");
    end
    if (Ae_level < 0 || Ae_level > Depth-1) begin : g_ae_chk
        $error("Ae_level out of range");
    end

    logic [Data_width-1:0] ram [Ram_depth];
    logic [Addr_width-1:0] wr_ptr, rd_ptr;
    logic [Addr_width:0]   ram_cnt, used_nxt;
    logic                  rd, bypass, ram_wr, ram_rd;

    function automatic logic [Addr_width-1:0] nxt(input logic [Addr_width-1:0] p);
        return (p == Addr_width'(Ram_depth-1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ack   = in_req && !full && !flush;
    assign rd       = out_req && out_ack && !flush;
    assign ram_cnt  = used - (Addr_width+1)'(out_req);
    // head replaced directly by the incoming word when it is the only one left
    assign bypass   = in_ack && rd && ram_cnt == '0;
    assign ram_wr   = in_ack && !bypass;
    assign ram_rd   = !flush && (!out_req || rd) && ram_cnt != '0;
    assign used_nxt = used + (Addr_width+1)'(in_ack) - (Addr_width+1)'(rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            used         <= '0;
            out_req      <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            proto_err    <= 1'b0;
        end else begin
            if (ram_wr) wr_ptr <= nxt(wr_ptr);
            if (ram_rd) rd_ptr <= nxt(rd_ptr);
            if (ram_rd || bypass) out_req <= 1'b1;
            else if (rd) out_req <= 1'b0;
            used         <= used_nxt;
            full         <= used_nxt == (Addr_width+1)'(Depth);
            empty        <= used_nxt == '0;
            almost_full  <= used_nxt >= (Addr_width+1)'(Af_level);
            almost_empty <= used_nxt <= (Addr_width+1)'(Ae_level);
            if (out_ack && !out_req) proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_wr) ram[wr_ptr] <= in_data;
        if (ram_rd) out_data <= ram[rd_ptr];
        else if (bypass) out_data <= in_data;
    end
endmodule
